// File: rtl/audio_pkg.sv
// Shared types and constants for the audio frame feeder and its FIFO.
package audio_pkg;

  // Codec word width; the feeder's SAMPLE_W parameter must equal this.
  localparam int SAMPLE_W = 16;

  // Bit positions inside channel_sel = {left_en, right_en}.
  localparam int CH_LEFT  = 1;
  localparam int CH_RIGHT = 0;

  // One stereo frame as stored in the FIFO.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

endpackage

// File: rtl/audio_frame_feeder_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// Reset flushes the FIFO by zeroing the pointers; storage is not cleared.
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  full_q, empty_q;
  logic                  push_ok, pop_ok;

  // Full blocks a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // Pointer and count next-state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with flags registered from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == DEPTH_CNT);
      empty_q  <= (cnt_d == '0);
    end
  end

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/audio_frame_feeder.sv
// Buffers stereo frames and hands one channel word to the codec per
// sample_end pulse: [0] pops a frame and emits left, [1] emits the held right.
// Optional build macro UNDERRUN_HOLD_EN: on underrun repeat the last left
// sample and keep the last right sample instead of outputting silence.
module audio_frame_feeder #(
  parameter int DEPTH_LOG2 = 3,
  parameter int SAMPLE_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [SAMPLE_W-1:0]   frame_left,
  input  logic [SAMPLE_W-1:0]   frame_right,
  input  logic [1:0]            sample_end,
  output logic [SAMPLE_W-1:0]   audio_output,
  output logic [1:0]            channel_sel,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           underrun_count,
  input  logic                  underrun_clr
);

  import audio_pkg::*;

  if (SAMPLE_W != audio_pkg::SAMPLE_W) begin : g_width_check
    $error("SAMPLE_W must match the codec word width");
  end

  frame_t        wr_frame, rd_frame;
  logic          fifo_full, fifo_empty;
  logic          pop_req, right_req, underrun;

  logic [SAMPLE_W-1:0] aout_q, aout_d;
  logic [SAMPLE_W-1:0] rhold_q, rhold_d;
  logic [15:0]         ucnt_q, ucnt_d;
  logic [1:0]          chsel_q;
  // Set by the first left request after enable rises; right requests are
  // ignored until then so a stream never opens on a right word.
  logic                started_q, started_d;
`ifdef UNDERRUN_HOLD_EN
  logic [SAMPLE_W-1:0] last_left_q, last_left_d;
`endif

  assign wr_frame = '{left: frame_left, right: frame_right};

  // Left request wins if the codec ever raises both bits together.
  assign pop_req   = enable && sample_end[0];
  assign right_req = enable && sample_end[1] && !sample_end[0];
  assign underrun  = pop_req && fifo_empty;

  // Ready is low throughout reset, then follows the registered full flag.
  assign frame_ready = !reset && !fifo_full;

  sync_fifo #(
    .WIDTH      ($bits(frame_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (frame_valid && !reset),
    .wdata_i (wr_frame),
    .pop_i   (pop_req),
    .rdata_o (rd_frame),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill_level)
  );

  // Output word, right-hold and underrun counter next-state.
  always_comb begin
    aout_d    = aout_q;
    rhold_d   = rhold_q;
    started_d = started_q;
    ucnt_d    = ucnt_q;
`ifdef UNDERRUN_HOLD_EN
    last_left_d = last_left_q;
`endif
    if (!enable) begin
      aout_d    = '0;
      started_d = 1'b0;
    end else if (pop_req) begin
      started_d = 1'b1;
      if (!fifo_empty) begin
        aout_d  = rd_frame.left;
        rhold_d = rd_frame.right;
`ifdef UNDERRUN_HOLD_EN
        last_left_d = rd_frame.left;
`endif
      end else begin
`ifdef UNDERRUN_HOLD_EN
        aout_d = last_left_q;
`else
        aout_d  = '0;
        rhold_d = '0;
`endif
      end
    end else if (right_req && started_q) begin
      aout_d = rhold_q;
    end

    if (underrun_clr)
      ucnt_d = underrun ? 16'd1 : 16'd0;
    else if (underrun && ucnt_q != 16'hFFFF)
      ucnt_d = ucnt_q + 16'd1;
  end

  // Output and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      aout_q    <= '0;
      rhold_q   <= '0;
      ucnt_q    <= '0;
      chsel_q   <= 2'b00;
      started_q <= 1'b0;
    end else begin
      aout_q             <= aout_d;
      rhold_q            <= rhold_d;
      ucnt_q             <= ucnt_d;
      chsel_q[CH_LEFT]   <= enable;
      chsel_q[CH_RIGHT]  <= enable;
      started_q          <= started_d;
    end
  end

`ifdef UNDERRUN_HOLD_EN
  // Last successfully popped left sample, replayed on underrun.
  always_ff @(posedge clk) begin
    if (reset) last_left_q <= '0;
    else       last_left_q <= last_left_d;
  end
`endif

  assign audio_output   = aout_q;
  assign channel_sel    = chsel_q;
  assign underrun_count = ucnt_q;

  a_no_dual_request: assert property (@(posedge clk) disable iff (reset)
    sample_end != 2'b11);

endmodule

// File: tb/tb_audio_frame_feeder.sv
// Scenario and randomized checks of audio_frame_feeder against a queue-based
// model of the stream behaviour.
module tb_audio_frame_feeder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, enable, frame_valid, underrun_clr;
  logic        frame_ready;
  logic [15:0] frame_left, frame_right, audio_output, underrun_count;
  logic [1:0]  sample_end, channel_sel;
  logic [3:0]  fill_level;

  int nvec = 0;
  int nerr = 0;

  // Reference model state.
  logic [31:0] mq[$];
  logic [15:0] m_aout, m_rh, m_last, m_cnt;
  logic [1:0]  m_ch;
  bit          m_started;

`ifdef UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  always #5 clk = ~clk;

  audio_frame_feeder #(.DEPTH_LOG2(3), .SAMPLE_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_left     (frame_left),
    .frame_right    (frame_right),
    .sample_end     (sample_end),
    .audio_output   (audio_output),
    .channel_sel    (channel_sel),
    .fill_level     (fill_level),
    .underrun_count (underrun_count),
    .underrun_clr   (underrun_clr)
  );

  // Advance one clock, updating the model from the inputs presented now.
  task automatic tick();
    bit          acc;
    logic [31:0] f;
    acc = !reset && frame_valid && (mq.size() < DEPTH);
    if (reset) begin
      mq.delete();
      m_aout = 0; m_rh = 0; m_last = 0; m_cnt = 0; m_ch = 0; m_started = 0;
    end else begin
      bit und;
      und  = 0;
      m_ch = {enable, enable};
      if (!enable) begin
        m_aout = 0; m_started = 0;
      end else if (sample_end[0]) begin
        m_started = 1;
        if (mq.size() > 0) begin
          f = mq.pop_front();
          m_aout = f[31:16]; m_rh = f[15:0]; m_last = f[31:16];
        end else begin
          und = 1;
          if (HOLD) m_aout = m_last;
          else begin m_aout = 0; m_rh = 0; end
        end
      end else if (sample_end[1] && m_started) begin
        m_aout = m_rh;
      end
      if (underrun_clr) m_cnt = und ? 16'd1 : 16'd0;
      else if (und && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (acc) mq.push_back({frame_left, frame_right});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] se);
    sample_end = se; tick(); sample_end = 2'b00;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    frame_valid = 1; frame_left = l; frame_right = r; tick(); frame_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; frame_valid = 0; underrun_clr = 0; sample_end = 0;
    frame_left = 0; frame_right = 0;
    #1;
    nvec++; if (frame_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready_during got=%b exp=0", frame_ready); end
    tick(); tick();
    nvec++; if (audio_output !== 16'h0) begin nerr++; $display("FAIL reset_aout got=%h exp=0", audio_output); end
    nvec++; if (fill_level !== 4'd0) begin nerr++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    nvec++; if (underrun_count !== 16'd0) begin nerr++; $display("FAIL reset_ucnt got=%0d exp=0", underrun_count); end
    nvec++; if (channel_sel !== 2'b00) begin nerr++; $display("FAIL reset_chsel got=%b exp=00", channel_sel); end
    reset = 0; #1;
    nvec++; if (frame_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready_after got=%b exp=1", frame_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_seq[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    enable = 1;
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    nvec++; if (fill_level !== 4'd2) begin nerr++; $display("FAIL basic_fill2 got=%0d exp=2", fill_level); end
    nvec++; if (channel_sel !== 2'b11) begin nerr++; $display("FAIL basic_chsel got=%b exp=11", channel_sel); end
    for (int i = 0; i < 4; i++) begin
      pulse((i % 2 == 0) ? 2'b01 : 2'b10);
      nvec++; if (audio_output !== exp_seq[i]) begin nerr++; $display("FAIL basic_word%0d got=%h exp=%h", i, audio_output, exp_seq[i]); end
      tick();
    end
    nvec++; if (fill_level !== 4'd0) begin nerr++; $display("FAIL basic_fill0 got=%0d exp=0", fill_level); end
  endtask

  task automatic test_full();
    frame_valid = 1;
    for (int i = 0; i < 8; i++) begin
      frame_left = 16'h0A00 + 16'(i); frame_right = 16'h0B00 + 16'(i); tick();
    end
    nvec++; if (frame_ready !== 1'b0) begin nerr++; $display("FAIL full_ready got=%b exp=0", frame_ready); end
    frame_left = 16'h9999; frame_right = 16'h9999; tick();
    nvec++; if (fill_level !== 4'd8) begin nerr++; $display("FAIL full_no9th got=%0d exp=8", fill_level); end
    pulse(2'b01);
    frame_valid = 0;
    nvec++; if (frame_ready !== 1'b1) begin nerr++; $display("FAIL full_ready_after_pop got=%b exp=1", frame_ready); end
    nvec++; if (audio_output !== 16'h0A00) begin nerr++; $display("FAIL full_first got=%h exp=0a00", audio_output); end
    for (int i = 1; i < 8; i++) begin
      pulse(2'b01);
      nvec++; if (audio_output !== 16'h0A00 + 16'(i)) begin nerr++; $display("FAIL full_drain%0d got=%h exp=%h", i, audio_output, 16'h0A00 + 16'(i)); end
    end
    nvec++; if (fill_level !== 4'd0) begin nerr++; $display("FAIL full_drained got=%0d exp=0", fill_level); end
  endtask

  task automatic test_underrun();
    logic [15:0] exp_u;
    exp_u = HOLD ? 16'h0A07 : 16'h0000;
    for (int i = 0; i < 3; i++) begin
      pulse(2'b01);
      nvec++; if (audio_output !== exp_u) begin nerr++; $display("FAIL under_aout%0d got=%h exp=%h", i, audio_output, exp_u); end
      tick();
    end
    nvec++; if (underrun_count !== 16'd3) begin nerr++; $display("FAIL under_cnt got=%0d exp=3", underrun_count); end
    underrun_clr = 1; tick(); underrun_clr = 0;
    nvec++; if (underrun_count !== 16'd0) begin nerr++; $display("FAIL under_clr got=%0d exp=0", underrun_count); end
    underrun_clr = 1; pulse(2'b01); underrun_clr = 0;
    nvec++; if (underrun_count !== 16'd1) begin nerr++; $display("FAIL under_clr_coinc got=%0d exp=1", underrun_count); end
    underrun_clr = 1; tick(); underrun_clr = 0;
  endtask

  task automatic test_disable();
    for (int i = 0; i < 4; i++) push(16'h0D00 + 16'(i), 16'h0E00 + 16'(i));
    enable = 0; tick();
    pulse(2'b01); pulse(2'b10); tick();
    nvec++; if (channel_sel !== 2'b00) begin nerr++; $display("FAIL dis_chsel got=%b exp=00", channel_sel); end
    nvec++; if (audio_output !== 16'h0) begin nerr++; $display("FAIL dis_aout got=%h exp=0", audio_output); end
    nvec++; if (fill_level !== 4'd4) begin nerr++; $display("FAIL dis_fill got=%0d exp=4", fill_level); end
    nvec++; if (underrun_count !== 16'd0) begin nerr++; $display("FAIL dis_ucnt got=%0d exp=0", underrun_count); end
    enable = 1; tick();
    pulse(2'b10);
    nvec++; if (audio_output !== 16'h0) begin nerr++; $display("FAIL dis_no_right_first got=%h exp=0", audio_output); end
    pulse(2'b01);
    nvec++; if (audio_output !== 16'h0D00) begin nerr++; $display("FAIL dis_resume_left got=%h exp=0d00", audio_output); end
    pulse(2'b10);
    nvec++; if (audio_output !== 16'h0E00) begin nerr++; $display("FAIL dis_resume_right got=%h exp=0e00", audio_output); end
    for (int i = 0; i < 3; i++) pulse(2'b01);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) push(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    pulse(2'b01);
    reset = 1; #1;
    nvec++; if (frame_ready !== 1'b0) begin nerr++; $display("FAIL mid_ready_during got=%b exp=0", frame_ready); end
    tick();
    nvec++; if (fill_level !== 4'd0) begin nerr++; $display("FAIL mid_fill got=%0d exp=0", fill_level); end
    nvec++; if (audio_output !== 16'h0) begin nerr++; $display("FAIL mid_aout got=%h exp=0", audio_output); end
    reset = 0; #1;
    nvec++; if (frame_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready_after got=%b exp=1", frame_ready); end
  endtask

  task automatic test_push_pop_same();
    for (int i = 0; i < 5; i++) push(16'h0C00 + 16'(i), 16'h0F00 + 16'(i));
    frame_valid = 1; frame_left = 16'h0C05; frame_right = 16'h0F05;
    pulse(2'b01); frame_valid = 0;
    nvec++; if (fill_level !== 4'd5) begin nerr++; $display("FAIL pp_fill got=%0d exp=5", fill_level); end
    nvec++; if (audio_output !== 16'h0C00) begin nerr++; $display("FAIL pp_first got=%h exp=0c00", audio_output); end
    for (int i = 1; i <= 5; i++) begin
      pulse(2'b01);
      nvec++; if (audio_output !== 16'h0C00 + 16'(i)) begin nerr++; $display("FAIL pp_order%0d got=%h exp=%h", i, audio_output, 16'h0C00 + 16'(i)); end
    end
  endtask

  task automatic test_random();
    logic [1:0] se_tab[5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    reset = 1; tick(); reset = 0;
    for (int n = 0; n < 600; n++) begin
      enable       = ($urandom_range(0, 9) != 0);
      frame_valid  = $urandom_range(0, 1);
      frame_left   = 16'($urandom);
      frame_right  = 16'($urandom);
      sample_end   = se_tab[$urandom_range(0, 4)];
      underrun_clr = ($urandom_range(0, 31) == 0);
      tick();
      nvec++; if (audio_output !== m_aout) begin nerr++; $display("FAIL rnd_aout cyc=%0d got=%h exp=%h", n, audio_output, m_aout); end
      nvec++; if (fill_level !== 4'(mq.size())) begin nerr++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", n, fill_level, mq.size()); end
      nvec++; if (frame_ready !== (mq.size() < DEPTH)) begin nerr++; $display("FAIL rnd_ready cyc=%0d got=%b", n, frame_ready); end
      nvec++; if (underrun_count !== m_cnt) begin nerr++; $display("FAIL rnd_ucnt cyc=%0d got=%0d exp=%0d", n, underrun_count, m_cnt); end
      nvec++; if (channel_sel !== m_ch) begin nerr++; $display("FAIL rnd_chsel cyc=%0d got=%b exp=%b", n, channel_sel, m_ch); end
    end
    frame_valid = 0; sample_end = 0; underrun_clr = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underrun();
    test_disable();
    test_reset_midstream();
    test_push_pop_same();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
